// File: rtl/mmio_write_bridge_if.sv
// Core-side, memory-side and channel-side signals of the MMIO write bridge.
// Ports: slave = bridge view, master = core/memory/consumer view.
interface mmio_write_bridge_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_LSB       = 8
);
    // core data port
    logic [31:0]                    i_addr;
    logic [31:0]                    i_write_data;
    logic [1:0]                     i_data_mask;
    logic                           i_write_en;
    logic                           i_read_en;
    logic [31:0]                    o_read_data;
    logic                           o_stall;
    // data memory port
    logic [31:0]                    o_mem_addr;
    logic [31:0]                    o_mem_write_data;
    logic [1:0]                     o_mem_data_mask;
    logic                           o_mem_write_en;
    logic                           o_mem_read_en;
    logic [31:0]                    i_mem_read_data;
    // per-channel FIFO heads
    logic [NUM_CHANNELS-1:0]        o_ch_valid;
    logic [NUM_CHANNELS*32-1:0]     o_ch_data;
    logic [NUM_CHANNELS*CH_LSB-1:0] o_ch_offset;
    logic [NUM_CHANNELS*2-1:0]      o_ch_mask;
    logic [NUM_CHANNELS-1:0]        i_ch_ready;
    logic                           o_decode_err;

    modport slave (
        input  i_addr, i_write_data, i_data_mask, i_write_en, i_read_en,
        input  i_mem_read_data, i_ch_ready,
        output o_read_data, o_stall,
        output o_mem_addr, o_mem_write_data, o_mem_data_mask,
        output o_mem_write_en, o_mem_read_en,
        output o_ch_valid, o_ch_data, o_ch_offset, o_ch_mask, o_decode_err
    );

    modport master (
        output i_addr, i_write_data, i_data_mask, i_write_en, i_read_en,
        output i_mem_read_data, i_ch_ready,
        input  o_read_data, o_stall,
        input  o_mem_addr, o_mem_write_data, o_mem_data_mask,
        input  o_mem_write_en, o_mem_read_en,
        input  o_ch_valid, o_ch_data, o_ch_offset, o_ch_mask, o_decode_err
    );
endinterface

// File: rtl/mmio_write_bridge.sv
// MMIO write bridge: routes I/O-window stores into per-channel write FIFOs,
// passes all other accesses to data memory, stalls the core on a full FIFO.
// Ports: clk, rst (async, active-high), bus (mmio_write_bridge_if.slave):
//   core port (addr/data/mask/strobes, read data, stall), memory pass-through,
//   per-channel head valid/data/offset/mask with consumer ready, sticky decode error.
module mmio_write_bridge #(
    parameter int          NUM_CHANNELS = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] IO_BASE      = 32'h8000_0000,
    parameter logic [31:0] IO_MASK      = 32'hFFFF_0000,
    parameter int          CH_LSB       = 8
) (
    input logic               clk,
    input logic               rst,
    mmio_write_bridge_if.slave bus
);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + CH_LSB + 2;

    logic              is_io;
    logic [CH_W-1:0]   ch;
    logic              ch_ok;
    logic              io_wr;
    logic              io_rd;
    logic              derr;

    logic [ENT_W-1:0]  fifo_mem [NUM_CHANNELS][FIFO_DEPTH];
    logic [ENT_W-1:0]  head     [NUM_CHANNELS];
    logic [PTR_W-1:0]  wr_ptr   [NUM_CHANNELS];
    logic [PTR_W-1:0]  rd_ptr   [NUM_CHANNELS];
    logic [CNT_W-1:0]  cnt      [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] full;
    logic [NUM_CHANNELS-1:0] empty;
    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] pop;

    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_full;
    logic              sel_empty;

    // Address decode
    assign is_io = (bus.i_addr & IO_MASK) == IO_BASE;
    assign ch    = bus.i_addr[CH_LSB +: CH_W];
    assign ch_ok = int'(ch) < NUM_CHANNELS;
    assign io_wr = bus.i_write_en & is_io;
    assign io_rd = bus.i_read_en & is_io;

    // Memory pass-through, no added latency
    assign bus.o_mem_addr       = bus.i_addr;
    assign bus.o_mem_write_data = bus.i_write_data;
    assign bus.o_mem_data_mask  = bus.i_data_mask;
    assign bus.o_mem_write_en   = bus.i_write_en & ~is_io;
    assign bus.o_mem_read_en    = bus.i_read_en & ~is_io;

    // Per-channel flags; a full FIFO refuses the push even if it pops this cycle
    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            full[c]  = cnt[c] == CNT_W'(FIFO_DEPTH);
            empty[c] = cnt[c] == '0;
            push[c]  = io_wr & ch_ok & (ch == CH_W'(c)) & ~full[c];
            pop[c]   = ~empty[c] & bus.i_ch_ready[c];
        end
    end

    // Status of the addressed channel
    always_comb begin
        sel_cnt   = '0;
        sel_full  = 1'b0;
        sel_empty = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch == CH_W'(c)) begin
                sel_cnt   = cnt[c];
                sel_full  = full[c];
                sel_empty = empty[c];
            end
        end
    end

    assign bus.o_stall = io_wr & ch_ok & sel_full;

    always_comb begin
        bus.o_read_data = '0;
        if (!is_io) begin
            bus.o_read_data = bus.i_mem_read_data;
        end else if (ch_ok) begin
            bus.o_read_data = {16'd0, 8'(sel_cnt), 6'd0, sel_full, sel_empty};
        end
    end

    // Pointers, counts and the sticky decode error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            derr <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                cnt[c] <= cnt[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            end
            if ((io_wr | io_rd) & ~ch_ok) derr <= 1'b1;
        end
    end

    // Entry storage needs no reset: heads are gated by the reset-cleared counts
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (push[c]) begin
                fifo_mem[c][wr_ptr[c]] <=
                    {bus.i_write_data, bus.i_addr[CH_LSB-1:0], bus.i_data_mask};
            end
        end
    end

    always_comb begin
        bus.o_ch_valid  = '0;
        bus.o_ch_data   = '0;
        bus.o_ch_offset = '0;
        bus.o_ch_mask   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            head[c] = fifo_mem[c][rd_ptr[c]];
            bus.o_ch_valid[c] = ~empty[c];
            if (!empty[c]) begin
                bus.o_ch_data[c*32 +: 32]         = head[c][ENT_W-1 -: 32];
                bus.o_ch_offset[c*CH_LSB +: CH_LSB] = head[c][CH_LSB+1 : 2];
                bus.o_ch_mask[c*2 +: 2]           = head[c][1:0];
            end
        end
    end

    assign bus.o_decode_err = derr;
endmodule

// File: tb/tb_mmio_write_bridge.sv
// Self-checking bench for mmio_write_bridge: vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_mmio_write_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_write_bridge_if #(.NUM_CHANNELS(4), .CH_LSB(8)) bus ();
    mmio_write_bridge_if #(.NUM_CHANNELS(3), .CH_LSB(8)) bus3 ();

    mmio_write_bridge #(
        .NUM_CHANNELS(4), .FIFO_DEPTH(4), .IO_BASE(32'h8000_0000),
        .IO_MASK(32'hFFFF_0000), .CH_LSB(8)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    mmio_write_bridge #(
        .NUM_CHANNELS(3), .FIFO_DEPTH(4), .IO_BASE(32'h8000_0000),
        .IO_MASK(32'hFFFF_0000), .CH_LSB(8)
    ) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  off;
        logic [1:0]  m;
    } ent_t;

    ent_t mq [4][$];

    task automatic model_clear();
        for (int c = 0; c < 4; c++) mq[c].delete();
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] m, input logic we, input logic re,
                         input logic [3:0] rdy, input logic [31:0] mrd);
        bus.i_addr          = a;
        bus.i_write_data    = wd;
        bus.i_data_mask     = m;
        bus.i_write_en      = we;
        bus.i_read_en       = re;
        bus.i_ch_ready      = rdy;
        bus.i_mem_read_data = mrd;
    endtask

    task automatic model_check();
        logic [31:0] a;
        bit io;
        int ch, n;
        logic [31:0] erd;
        a  = bus.i_addr;
        io = (a[31:16] == 16'h8000);
        ch = (a >> 8) % 4;
        n  = mq[ch].size();
        if (!io) erd = bus.i_mem_read_data;
        else erd = (n << 8) | ((n == 4) ? 2 : 0) | ((n == 0) ? 1 : 0);
        check("stall", bus.o_stall, bus.i_write_en && io && n == 4);
        check("rdata", bus.o_read_data, erd);
        check("mem_we", bus.o_mem_write_en, bus.i_write_en && !io);
        check("mem_re", bus.o_mem_read_en, bus.i_read_en && !io);
        check("mem_addr", bus.o_mem_addr, a);
        check("mem_wd", bus.o_mem_write_data, bus.i_write_data);
        check("mem_mask", bus.o_mem_data_mask, bus.i_data_mask);
        check("derr", bus.o_decode_err, 0);
        for (int c = 0; c < 4; c++) begin
            ent_t e;
            e = (mq[c].size() > 0) ? mq[c][0] : '0;
            check($sformatf("ch%0d_valid", c), bus.o_ch_valid[c], mq[c].size() > 0);
            check($sformatf("ch%0d_data", c), bus.o_ch_data[c*32 +: 32], e.d);
            check($sformatf("ch%0d_off", c), bus.o_ch_offset[c*8 +: 8], e.off);
            check($sformatf("ch%0d_mask", c), bus.o_ch_mask[c*2 +: 2], e.m);
        end
    endtask

    task automatic model_edge();
        logic [31:0] a;
        bit io;
        int ch, n;
        ent_t e;
        a  = bus.i_addr;
        io = (a[31:16] == 16'h8000);
        ch = (a >> 8) % 4;
        n  = mq[ch].size();
        for (int c = 0; c < 4; c++)
            if (mq[c].size() > 0 && bus.i_ch_ready[c]) void'(mq[c].pop_front());
        if (bus.i_write_en && io && n < 4) begin
            e.d   = bus.i_write_data;
            e.off = a[7:0];
            e.m   = bus.i_data_mask;
            mq[ch].push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] memrd;
        logic        exp_stall;
        logic [31:0] exp_rd;
        logic        exp_mwe;
        logic        exp_mre;
        logic [3:0]  exp_valid;
        int          dch;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{32'h8000_0104, 32'hDEAD_BEEF, 1, 0, 0, 0, 32'h1, 0, 0, 4'b0000, 1, 0};
        tbl[1]  = '{32'h8000_0104, 0, 0, 1, 0, 0, 32'h100, 0, 0, 4'b0010, 1, 32'hDEAD_BEEF};
        tbl[2]  = '{32'h8000_0000, 32'h100, 1, 0, 0, 0, 32'h1, 0, 0, 4'b0010, 0, 0};
        tbl[3]  = '{32'h8000_0000, 32'h101, 1, 0, 0, 0, 32'h100, 0, 0, 4'b0011, 0, 32'h100};
        tbl[4]  = '{32'h8000_0000, 32'h102, 1, 0, 0, 0, 32'h200, 0, 0, 4'b0011, 0, 32'h100};
        tbl[5]  = '{32'h8000_0000, 32'h103, 1, 0, 0, 0, 32'h300, 0, 0, 4'b0011, 0, 32'h100};
        tbl[6]  = '{32'h8000_0000, 32'h104, 1, 0, 0, 1, 32'h402, 0, 0, 4'b0011, 0, 32'h100};
        tbl[7]  = '{32'h8000_0000, 0, 0, 1, 0, 0, 32'h402, 0, 0, 4'b0011, 0, 32'h100};
        tbl[8]  = '{32'h0000_0010, 32'h1234, 1, 0, 32'hCAFE_0000, 0, 32'hCAFE_0000,
                    1, 0, 4'b0011, 1, 32'hDEAD_BEEF};
        tbl[9]  = '{32'h8000_0200, 0, 0, 1, 32'hCAFE_0000, 0, 32'h1, 0, 0, 4'b0011, 2, 0};
        tbl[10] = '{32'h0000_0040, 0, 0, 1, 32'h5A5A_1234, 0, 32'h5A5A_1234,
                    0, 1, 4'b0011, 0, 32'h100};
        tbl[11] = '{32'h8000_0000, 0, 0, 1, 0, 0, 32'h402, 0, 0, 4'b0011, 0, 32'h100};
        tbl[12] = '{32'h8001_0000, 32'h55, 1, 0, 0, 0, 32'h0, 1, 0, 4'b0011, 0, 32'h100};
        tbl[13] = '{32'h8000_0104, 0, 0, 1, 0, 0, 32'h100, 0, 0, 4'b0011, 1, 32'hDEAD_BEEF};
    end

    // ---------------- main sequence ----------------
    initial begin
        drive(0, 0, 0, 0, 0, 4'b0, 0);
        bus3.i_addr = 0; bus3.i_write_data = 0; bus3.i_data_mask = 0;
        bus3.i_write_en = 0; bus3.i_read_en = 0;
        bus3.i_ch_ready = 0; bus3.i_mem_read_data = 0;

        // reset state
        #3;
        check("rst_valid", bus.o_ch_valid, 0);
        check("rst_data", bus.o_ch_data, 0);
        check("rst_off", bus.o_ch_offset, 0);
        check("rst_mask", bus.o_ch_mask, 0);
        check("rst_derr", bus.o_decode_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // out-of-range channel on the 3-channel instance
        bus3.i_addr = 32'h8000_0300;
        bus3.i_write_data = 32'h77;
        bus3.i_write_en = 1;
        #2;
        check("oor_stall", bus3.o_stall, 0);
        check("oor_derr_pre", bus3.o_decode_err, 0);
        check("oor_mem_we", bus3.o_mem_write_en, 0);
        @(posedge clk);
        #1;
        check("oor_derr_set", bus3.o_decode_err, 1);
        check("oor_no_push", bus3.o_ch_valid, 0);
        bus3.i_write_en = 0;
        bus3.i_read_en = 1;
        #2;
        check("oor_load", bus3.o_read_data, 0);
        bus3.i_read_en = 0;
        bus3.i_addr = 32'h8000_0208;
        bus3.i_write_data = 32'h99;
        bus3.i_write_en = 1;
        @(posedge clk);
        #1;
        bus3.i_write_en = 0;
        check("oor_derr_sticky", bus3.o_decode_err, 1);
        check("ch2_valid3", bus3.o_ch_valid, 3'b100);
        check("ch2_data3", bus3.o_ch_data[95:64], 32'h99);
        check("ch2_off3", bus3.o_ch_offset[23:16], 8'h08);
        pulse_reset();
        check("derr_cleared", bus3.o_decode_err, 0);

        // table-driven vectors, all consumers stalled
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].addr, tbl[i].wdata, 2'b10, tbl[i].we, tbl[i].re,
                  4'b0, tbl[i].memrd);
            @(negedge clk);
            check($sformatf("t%0d_stall", i), bus.o_stall, tbl[i].exp_stall);
            check($sformatf("t%0d_rd", i), bus.o_read_data, tbl[i].exp_rd);
            check($sformatf("t%0d_mwe", i), bus.o_mem_write_en, tbl[i].exp_mwe);
            check($sformatf("t%0d_mre", i), bus.o_mem_read_en, tbl[i].exp_mre);
            check($sformatf("t%0d_valid", i), bus.o_ch_valid, tbl[i].exp_valid);
            check($sformatf("t%0d_data", i), bus.o_ch_data[tbl[i].dch*32 +: 32],
                  tbl[i].exp_data);
            @(posedge clk);
            #1;
        end
        check("ch1_off", bus.o_ch_offset[15:8], 8'h04);
        check("ch1_mask", bus.o_ch_mask[3:2], 2'b10);

        // push and pop on the same cycle at count 2
        pulse_reset();
        drive(32'h8000_0000, 32'hA0, 2'b01, 1, 0, 4'b0, 0); cycle();
        drive(32'h8000_0000, 32'hA1, 2'b01, 1, 0, 4'b0, 0); cycle();
        drive(32'h8000_0000, 32'hA2, 2'b01, 1, 0, 4'b0001, 0);
        #2;
        check("pp_stall", bus.o_stall, 0);
        cycle();
        drive(32'h8000_0000, 0, 0, 0, 1, 4'b0, 0);
        #2;
        check("pp_count", bus.o_read_data, 32'h200);
        check("pp_head1", bus.o_ch_data[31:0], 32'hA1);
        cycle();
        drive(32'h8000_0000, 0, 0, 0, 0, 4'b0001, 0); cycle();
        check("pp_head2", bus.o_ch_data[31:0], 32'hA2);
        cycle();
        check("pp_empty", bus.o_ch_valid[0], 0);

        // full FIFO stalls even while popping
        for (int k = 0; k < 4; k++) begin
            drive(32'h8000_0000, 32'hB0 + k, 2'b11, 1, 0, 4'b0, 0);
            cycle();
        end
        drive(32'h8000_0000, 32'hBF, 2'b11, 1, 0, 4'b0001, 0);
        #2;
        check("full_pop_stall", bus.o_stall, 1);
        cycle();
        drive(32'h8000_0000, 0, 0, 0, 1, 4'b0, 0);
        #2;
        check("full_pop_count", bus.o_read_data, 32'h300);
        cycle();

        // asynchronous reset with entries held in ch3
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            drive(32'h8000_0310 + k, 32'hC0 + k, 2'b00, 1, 0, 4'b0, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 4'b0, 0);
        check("ch3_held", bus.o_ch_valid[3], 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_valid", bus.o_ch_valid, 0);
        check("async_data", bus.o_ch_data[127:96], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        drive(32'h8000_0300, 0, 0, 0, 1, 4'b0, 0);
        #2;
        check("ch3_after_rst", bus.o_read_data, 32'h1);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            int r, ch;
            logic [31:0] a;
            logic [3:0] rdy;
            r  = $urandom_range(0, 9);
            ch = $urandom_range(0, 3);
            if (r < 6) a = 32'h8000_0000 | (32'(ch) << 8) | 32'($urandom_range(0, 255));
            else if (r < 9) a = $urandom & 32'h7FFF_FFFC;
            else a = 32'h8001_0000 | ($urandom & 32'hFFFF);
            for (int c = 0; c < 4; c++) rdy[c] = ($urandom_range(0, 2) == 0);
            if (i % 100 > 80) rdy = 4'hF;
            drive(a, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  rdy, $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
